// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: compacts fetch packets into a circular per-instruction FIFO.
// Optional FETCH_QUEUE_PERF_EN adds saturating full/empty cycle counters.
package cpu_params;
   localparam int IF_WIDTH = 2;
   localparam int ID_WIDTH = 2;

   typedef struct packed {
      logic [IF_WIDTH-1:0][31:0] inst;
      logic [IF_WIDTH-1:0]       predict_taken;
      logic [IF_WIDTH-1:0][31:0] predict_target;
      logic [31:0]               pc;
      logic [IF_WIDTH-1:0]       valid;
   } fetch_packet_t;
endpackage

module fetch_queue #(
   parameter int DEPTH    = 16,
   // must match cpu_params since fetch_packet_t is sized from the package
   parameter int IF_WIDTH = cpu_params::IF_WIDTH,
   parameter int ID_WIDTH = cpu_params::ID_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef FETCH_QUEUE_PERF_EN
   output logic [31:0]                  perf_full_cycles,
   output logic [31:0]                  perf_empty_cycles,
`endif
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  cpu_params::fetch_packet_t    in_packet,
   output logic [ID_WIDTH-1:0]          out_valid,
   input  logic                         out_ready,
   output logic [ID_WIDTH-1:0][31:0]    out_inst,
   output logic [ID_WIDTH-1:0][31:0]    out_pc,
   output logic [ID_WIDTH-1:0]          out_predict_taken,
   output logic [ID_WIDTH-1:0][31:0]    out_predict_target
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - IF_WIDTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
   } entry_t;

   entry_t                      mem_q [DEPTH];
   logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]               count_q, count_d;
   logic [CW-1:0]               n_enq, n_deq;
   logic [IF_WIDTH-1:0][PW-1:0] woff;
   logic                        enq;

   assign in_ready = (count_q <= FULL_TH);
   assign enq      = in_valid && in_ready;

   // Each valid slot lands at tail plus the number of valid slots below it.
   always_comb begin
      n_enq = '0;
      woff  = '0;
      for (int i = 0; i < IF_WIDTH; i++) begin
         woff[i] = tail_q + n_enq[PW-1:0];
         if (in_packet.valid[i]) n_enq = n_enq + CW'(1);
      end
      if (!enq) n_enq = '0;
   end

   always_comb begin
      n_deq = '0;
      for (int i = 0; i < ID_WIDTH; i++)
         if (out_ready && out_valid[i]) n_deq = n_deq + CW'(1);
   end

   always_comb begin
      head_d  = head_q + n_deq[PW-1:0];
      tail_d  = tail_q + n_enq[PW-1:0];
      count_d = count_q + n_enq - n_deq;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; contents only matter where out_valid is set.
   always_ff @(posedge clk) begin
      if (enq && !flush) begin
         for (int i = 0; i < IF_WIDTH; i++) begin
            if (in_packet.valid[i]) begin
               mem_q[woff[i]].inst   <= in_packet.inst[i];
               mem_q[woff[i]].pc     <= in_packet.pc + 32'(4 * i);
               mem_q[woff[i]].target <= in_packet.predict_target[i];
               mem_q[woff[i]].taken  <= in_packet.predict_taken[i];
            end
         end
      end
   end

   for (genvar g = 0; g < ID_WIDTH; g++) begin : g_out
      wire [PW-1:0] ridx = head_q + PW'(g);
      assign out_valid[g]          = (count_q > CW'(g));
      assign out_inst[g]           = mem_q[ridx].inst;
      assign out_pc[g]             = mem_q[ridx].pc;
      assign out_predict_taken[g]  = mem_q[ridx].taken;
      assign out_predict_target[g] = mem_q[ridx].target;
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] full_cyc_q, empty_cyc_q;

   // Counters survive flush; only rst clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_cyc_q  <= '0;
         empty_cyc_q <= '0;
      end else begin
         if (in_valid && !in_ready && full_cyc_q != '1)
            full_cyc_q <= full_cyc_q + 32'd1;
         if (count_q == '0 && !flush && empty_cyc_q != '1)
            empty_cyc_q <= empty_cyc_q + 32'd1;
      end
   end

   assign perf_full_cycles  = full_cyc_q;
   assign perf_empty_cycles = empty_cyc_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=16, IF_WIDTH=ID_WIDTH=2).
module tb_fetch_queue;
   logic                       clk = 0;
   logic                       rst, flush, in_valid, in_ready, out_ready;
   cpu_params::fetch_packet_t  in_packet;
   logic [1:0]                 out_valid, out_predict_taken;
   logic [1:0][31:0]           out_inst, out_pc, out_predict_target;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0]                perf_full_cycles, perf_empty_cycles;
`endif
   int pass_cnt = 0;
   int total    = 0;

   fetch_queue #(.DEPTH(16)) dut (
      .clk(clk), .rst(rst),
`ifdef FETCH_QUEUE_PERF_EN
      .perf_full_cycles(perf_full_cycles), .perf_empty_cycles(perf_empty_cycles),
`endif
      .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_predict_taken(out_predict_taken), .out_predict_target(out_predict_target));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic cpu_params::fetch_packet_t mkpkt(logic [31:0] pc, logic [31:0] i0,
                                                       logic [31:0] i1, logic [1:0] v);
      cpu_params::fetch_packet_t p;
      p = '0;
      p.pc = pc;
      p.inst[0] = i0;
      p.inst[1] = i1;
      p.valid = v;
      p.predict_taken = 2'b10;
      p.predict_target[1] = pc + 32'h100;
      return p;
   endfunction

   task automatic test_reset();
      rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_packet = '0;
      step();
      total++; if (out_valid !== 2'b00) $display("FAIL reset_out_valid got %b exp 00", out_valid); else pass_cnt++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
      total++; if (dut.count_q !== 5'd0) $display("FAIL reset_count got %0d exp 0", dut.count_q); else pass_cnt++;
      rst = 0;
      step();
   endtask

   task automatic test_basic();
      in_packet = mkpkt(32'h1000, 32'h00500093, 32'h00A00113, 2'b11);
      in_valid = 1;
      step();
      in_valid = 0;
      total++; if (out_valid !== 2'b11) $display("FAIL basic_valid got %b exp 11", out_valid); else pass_cnt++;
      total++; if (out_pc[0] !== 32'h1000) $display("FAIL basic_pc0 got %h exp 1000", out_pc[0]); else pass_cnt++;
      total++; if (out_pc[1] !== 32'h1004) $display("FAIL basic_pc1 got %h exp 1004", out_pc[1]); else pass_cnt++;
      total++; if (out_inst[0] !== 32'h00500093) $display("FAIL basic_inst0 got %h exp 00500093", out_inst[0]); else pass_cnt++;
      total++; if (out_inst[1] !== 32'h00A00113) $display("FAIL basic_inst1 got %h exp 00a00113", out_inst[1]); else pass_cnt++;
      total++; if (out_predict_taken !== 2'b10) $display("FAIL basic_taken got %b exp 10", out_predict_taken); else pass_cnt++;
      total++; if (out_predict_target[1] !== 32'h1100) $display("FAIL basic_target got %h exp 1100", out_predict_target[1]); else pass_cnt++;
      out_ready = 1;
      step();
      out_ready = 0;
      total++; if (out_valid !== 2'b00) $display("FAIL basic_drain_valid got %b exp 00", out_valid); else pass_cnt++;
      total++; if (dut.count_q !== 5'd0) $display("FAIL basic_drain_count got %0d exp 0", dut.count_q); else pass_cnt++;
   endtask

   task automatic test_partial();
      in_packet = mkpkt(32'h2000, 32'h0000AAAA, 32'h00C00193, 2'b10);
      in_valid = 1;
      step();
      in_valid = 0;
      total++; if (out_valid !== 2'b01) $display("FAIL partial_valid got %b exp 01", out_valid); else pass_cnt++;
      total++; if (out_pc[0] !== 32'h2004) $display("FAIL partial_pc got %h exp 2004", out_pc[0]); else pass_cnt++;
      total++; if (out_inst[0] !== 32'h00C00193) $display("FAIL partial_inst got %h exp 00c00193", out_inst[0]); else pass_cnt++;
      total++; if (out_predict_taken[0] !== 1'b1) $display("FAIL partial_taken got %b exp 1", out_predict_taken[0]); else pass_cnt++;
      out_ready = 1;
      step();
      out_ready = 0;
      total++; if (dut.count_q !== 5'd0) $display("FAIL partial_drain_count got %0d exp 0", dut.count_q); else pass_cnt++;
   endtask

   // head sits at 3 here, so eight full packets wrap the pointers
   task automatic test_full_wrap();
      for (int k = 0; k < 8; k++) begin
         total++; if (in_ready !== 1'b1) $display("FAIL fill_ready k=%0d got %b exp 1", k, in_ready); else pass_cnt++;
         in_packet = mkpkt(32'h4000 + 32'(8 * k), 32'h100 + 32'(2 * k), 32'h101 + 32'(2 * k), 2'b11);
         in_valid = 1;
         step();
      end
      in_valid = 0;
      total++; if (in_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", in_ready); else pass_cnt++;
      total++; if (dut.count_q !== 5'd16) $display("FAIL full_count got %0d exp 16", dut.count_q); else pass_cnt++;
      in_packet = mkpkt(32'h9000, 32'hDEAD, 32'hBEEF, 2'b11);
      in_valid = 1;
      step();
      in_valid = 0;
      total++; if (dut.count_q !== 5'd16) $display("FAIL full_blocked_count got %0d exp 16", dut.count_q); else pass_cnt++;
      out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         total++; if (out_valid !== 2'b11) $display("FAIL drain_valid k=%0d got %b exp 11", k, out_valid); else pass_cnt++;
         total++; if (out_inst[0] !== 32'h100 + 32'(2 * k)) $display("FAIL drain_inst0 k=%0d got %h exp %h", k, out_inst[0], 32'h100 + 32'(2 * k)); else pass_cnt++;
         total++; if (out_inst[1] !== 32'h101 + 32'(2 * k)) $display("FAIL drain_inst1 k=%0d got %h exp %h", k, out_inst[1], 32'h101 + 32'(2 * k)); else pass_cnt++;
         total++; if (out_pc[1] !== 32'h4004 + 32'(8 * k)) $display("FAIL drain_pc1 k=%0d got %h exp %h", k, out_pc[1], 32'h4004 + 32'(8 * k)); else pass_cnt++;
         step();
      end
      out_ready = 0;
      total++; if (out_valid !== 2'b00) $display("FAIL drain_empty got %b exp 00", out_valid); else pass_cnt++;
   endtask

   task automatic test_count15();
      for (int k = 0; k < 7; k++) begin
         in_packet = mkpkt(32'h5000 + 32'(8 * k), 32'h200 + 32'(2 * k), 32'h201 + 32'(2 * k), 2'b11);
         in_valid = 1;
         step();
      end
      in_packet = mkpkt(32'h5038, 32'h20E, 32'h20F, 2'b01);
      step();
      in_valid = 0;
      total++; if (dut.count_q !== 5'd15) $display("FAIL c15_count got %0d exp 15", dut.count_q); else pass_cnt++;
      total++; if (in_ready !== 1'b0) $display("FAIL c15_ready got %b exp 0", in_ready); else pass_cnt++;
      in_packet = mkpkt(32'h6000, 32'h300, 32'h301, 2'b11);
      in_valid = 1;
      step();
      total++; if (dut.count_q !== 5'd15) $display("FAIL c15_blocked got %0d exp 15", dut.count_q); else pass_cnt++;
      out_ready = 1;
      step();
      in_valid = 0; out_ready = 0;
      total++; if (dut.count_q !== 5'd13) $display("FAIL c15_deq_count got %0d exp 13", dut.count_q); else pass_cnt++;
      total++; if (in_ready !== 1'b1) $display("FAIL c15_ready_after got %b exp 1", in_ready); else pass_cnt++;
      total++; if (out_inst[0] !== 32'h202) $display("FAIL c15_head_inst got %h exp 202", out_inst[0]); else pass_cnt++;
      flush = 1;
      step();
      flush = 0;
      total++; if (dut.count_q !== 5'd0) $display("FAIL c15_flush_count got %0d exp 0", dut.count_q); else pass_cnt++;
   endtask

   task automatic test_flush();
      for (int k = 0; k < 4; k++) begin
         in_packet = mkpkt(32'h7000 + 32'(8 * k), 32'h400 + 32'(2 * k), 32'h401 + 32'(2 * k), 2'b11);
         in_valid = 1;
         step();
      end
      in_packet = mkpkt(32'h7020, 32'h408, 32'h409, 2'b01);
      step();
      total++; if (dut.count_q !== 5'd9) $display("FAIL flush_pre_count got %0d exp 9", dut.count_q); else pass_cnt++;
      in_packet = mkpkt(32'h7100, 32'h500, 32'h501, 2'b11);
      flush = 1; out_ready = 1;
      step();
      flush = 0; in_valid = 0; out_ready = 0;
      total++; if (dut.count_q !== 5'd0) $display("FAIL flush_count got %0d exp 0", dut.count_q); else pass_cnt++;
      total++; if (out_valid !== 2'b00) $display("FAIL flush_valid got %b exp 00", out_valid); else pass_cnt++;
      total++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %b exp 1", in_ready); else pass_cnt++;
      step();
      total++; if (out_valid !== 2'b00) $display("FAIL flush_stays_empty got %b exp 00", out_valid); else pass_cnt++;
      in_packet = mkpkt(32'h8000, 32'h600, 32'h601, 2'b11);
      in_valid = 1;
      step();
      in_valid = 0;
      total++; if (out_inst[0] !== 32'h600) $display("FAIL flush_refill_inst got %h exp 600", out_inst[0]); else pass_cnt++;
      total++; if (out_pc[0] !== 32'h8000) $display("FAIL flush_refill_pc got %h exp 8000", out_pc[0]); else pass_cnt++;
      out_ready = 1;
      step();
      out_ready = 0;
   endtask

   task automatic test_back_to_back();
      in_valid = 1; out_ready = 1;
      for (int k = 0; k < 6; k++) begin
         in_packet = mkpkt(32'hA000 + 32'(8 * k), 32'h700 + 32'(2 * k), 32'h701 + 32'(2 * k), 2'b11);
         step();
         total++; if (out_valid !== 2'b11) $display("FAIL b2b_valid k=%0d got %b exp 11", k, out_valid); else pass_cnt++;
         total++; if (out_inst[0] !== 32'h700 + 32'(2 * k)) $display("FAIL b2b_inst0 k=%0d got %h exp %h", k, out_inst[0], 32'h700 + 32'(2 * k)); else pass_cnt++;
         total++; if (out_inst[1] !== 32'h701 + 32'(2 * k)) $display("FAIL b2b_inst1 k=%0d got %h exp %h", k, out_inst[1], 32'h701 + 32'(2 * k)); else pass_cnt++;
      end
      in_valid = 0;
      step();
      out_ready = 0;
      total++; if (out_valid !== 2'b00) $display("FAIL b2b_empty got %b exp 00", out_valid); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      in_packet = mkpkt(32'hB000, 32'h800, 32'h801, 2'b11);
      in_valid = 1;
      step();
      in_valid = 0;
      #2 rst = 1;
      #1;
      total++; if (out_valid !== 2'b00) $display("FAIL async_rst_valid got %b exp 00", out_valid); else pass_cnt++;
      total++; if (dut.count_q !== 5'd0) $display("FAIL async_rst_count got %0d exp 0", dut.count_q); else pass_cnt++;
      step();
      rst = 0;
      step();
   endtask

`ifdef FETCH_QUEUE_PERF_EN
   task automatic test_perf();
      rst = 1;
      step();
      rst = 0;
      step(); step(); step();
      total++; if (perf_empty_cycles !== 32'd3) $display("FAIL perf_empty got %0d exp 3", perf_empty_cycles); else pass_cnt++;
      for (int k = 0; k < 8; k++) begin
         in_packet = mkpkt(32'hC000 + 32'(8 * k), 32'h900 + 32'(k), 32'h980 + 32'(k), 2'b11);
         in_valid = 1;
         step();
      end
      total++; if (perf_full_cycles !== 32'd0) $display("FAIL perf_full_pre got %0d exp 0", perf_full_cycles); else pass_cnt++;
      for (int k = 0; k < 5; k++) step();
      in_valid = 0;
      total++; if (perf_full_cycles !== 32'd5) $display("FAIL perf_full got %0d exp 5", perf_full_cycles); else pass_cnt++;
      flush = 1;
      step();
      flush = 0;
      total++; if (perf_full_cycles !== 32'd5) $display("FAIL perf_full_flush got %0d exp 5", perf_full_cycles); else pass_cnt++;
      rst = 1;
      #1;
      total++; if (perf_full_cycles !== 32'd0) $display("FAIL perf_full_rst got %0d exp 0", perf_full_cycles); else pass_cnt++;
      step();
      rst = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_full_wrap();
      test_count15();
      test_flush();
      test_back_to_back();
      test_async_reset();
`ifdef FETCH_QUEUE_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
